// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA1 byte host and its word packer.
// The message limit leaves room for padding inside the 1024 x 64b SHA1 memory.
package sha1_pkg;

   localparam int SHA1_DIGEST_BYTES = 20;
   localparam int SHA1_WORD_BYTES   = 8;
   localparam int SHA1_MEM_WORDS    = 1024;
   localparam int SHA1_MAX_BYTES    = SHA1_MEM_WORDS * SHA1_WORD_BYTES - 256;

   typedef enum logic [2:0] {
      ST_CLEAR  = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_EMIT   = 3'd5
   } sha1_state_e;

   function automatic logic [7:0] lanes_to_bits(input logic [3:0] lanes);
      return {1'b0, lanes, 3'b000};
   endfunction

endpackage

// File: rtl/sha1_byte_packer.sv
// Packs message bytes little-lane-first into 64-bit words and presents each
// completed or flushed word to the SHA1 write port for exactly one cycle.
module sha1_byte_packer
   import sha1_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr_i,
   input  logic        byte_we_i,
   input  logic [7:0]  byte_i,
   input  logic        flush_i,
   output logic [2:0]  lane_o,
   output logic [63:0] word_o,
   output logic [7:0]  len_o,
   output logic        write_o
);

   logic [63:0] pack_q;
   logic [2:0]  lane_q;
   logic [63:0] word_q;
   logic [7:0]  len_q;
   logic        write_q;

   // A full word moves to the output register on the same edge its 8th byte
   // arrives, so the pack register is free for the next byte immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pack_q  <= 64'd0;
         lane_q  <= 3'd0;
         word_q  <= 64'd0;
         len_q   <= 8'd0;
         write_q <= 1'b0;
      end else if (clr_i) begin
         pack_q  <= 64'd0;
         lane_q  <= 3'd0;
         word_q  <= 64'd0;
         len_q   <= 8'd0;
         write_q <= 1'b0;
      end else begin
         write_q <= 1'b0;
         if (flush_i) begin
            word_q  <= pack_q;
            len_q   <= lanes_to_bits({1'b0, lane_q});
            write_q <= 1'b1;
            pack_q  <= 64'd0;
            lane_q  <= 3'd0;
         end else if (byte_we_i) begin
            lane_q <= lane_q + 3'd1;
            if (lane_q == 3'd7) begin
               word_q  <= {byte_i, pack_q[55:0]};
               len_q   <= lanes_to_bits(4'(SHA1_WORD_BYTES));
               write_q <= 1'b1;
               pack_q  <= 64'd0;
            end else begin
               pack_q[{lane_q, 3'b000} +: 8] <= byte_i;
            end
         end else begin
            pack_q <= pack_q;
         end
      end
   end

   assign lane_o  = lane_q;
   assign word_o  = word_q;
   assign len_o   = len_q;
   assign write_o = write_q;

endmodule

// File: rtl/sha1_byte_host.sv
// Initiator for the SHA1 core: streams a message in as bytes, loads it into the
// core, starts the hash and streams the 20-byte digest back out.
module sha1_byte_host
   import sha1_pkg::*;
#(
   parameter int MAX_BYTES = SHA1_MAX_BYTES
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [7:0]   s_data,
   input  logic         s_last,
   input  logic         s_empty,
   output logic         d_valid,
   input  logic         d_ready,
   output logic [7:0]   d_data,
   output logic         d_last,
   output logic         err,
   output logic         busy,
   output logic [63:0]  sha_in_data,
   output logic [7:0]   sha_in_len,
   output logic         sha_write,
   output logic         sha_start,
   output logic         sha_reset,
   input  logic [159:0] sha_digest,
   input  logic         sha_ready
);

   localparam logic [12:0] MAX_CNT  = 13'(MAX_BYTES);
   localparam logic [4:0]  LAST_IDX = 5'(SHA1_DIGEST_BYTES - 1);

   sha1_state_e  state_q;
   logic [12:0]  cnt_q;
   logic         drop_q;
   logic [159:0] shift_q;
   logic [4:0]   idx_q;
   logic         s_ready_q;
   logic         d_valid_q;
   logic         d_last_q;
   logic         err_q;
   logic         busy_q;
   logic         sha_start_q;
   logic         sha_reset_q;

   logic         hs_s;
   logic         empty_s;
   logic         take_s;
   logic         ovf_s;
   logic         keep_s;
   logic [2:0]   lane_s;

   assign hs_s    = s_valid & s_ready_q & (state_q == ST_ACCEPT);
   assign empty_s = hs_s & s_last & s_empty;
   assign take_s  = hs_s & ~empty_s;
   // The byte that would become number MAX_BYTES+1 is the first one dropped.
   assign ovf_s   = take_s & (cnt_q == MAX_CNT);
   assign keep_s  = take_s & ~drop_q & ~ovf_s;

   sha1_byte_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (state_q == ST_CLEAR),
      .byte_we_i (keep_s),
      .byte_i    (s_data),
      .flush_i   (state_q == ST_FLUSH),
      .lane_o    (lane_s),
      .word_o    (sha_in_data),
      .len_o     (sha_in_len),
      .write_o   (sha_write)
   );

   // Message/digest sequencing; all handshake and core controls are registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= 13'd0;
         drop_q      <= 1'b0;
         shift_q     <= 160'd0;
         idx_q       <= 5'd0;
         s_ready_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         d_last_q    <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b1;
         sha_start_q <= 1'b0;
         sha_reset_q <= 1'b0;
      end else begin
         err_q       <= 1'b0;
         sha_start_q <= 1'b0;
         sha_reset_q <= 1'b0;
         case (state_q)
            ST_CLEAR: begin
               sha_reset_q <= 1'b1;
               s_ready_q   <= 1'b1;
               busy_q      <= 1'b0;
               cnt_q       <= 13'd0;
               drop_q      <= 1'b0;
               state_q     <= ST_ACCEPT;
            end
            ST_ACCEPT: begin
               if (hs_s) begin
                  busy_q <= 1'b1;
                  if (take_s && (cnt_q != 13'h1FFF)) begin
                     cnt_q <= cnt_q + 13'd1;
                  end
                  if (ovf_s) begin
                     drop_q <= 1'b1;
                  end
                  if (s_last) begin
                     s_ready_q <= 1'b0;
                     if (drop_q || ovf_s) begin
                        err_q   <= 1'b1;
                        state_q <= ST_CLEAR;
                     end else if (empty_s) begin
                        state_q <= (lane_s != 3'd0) ? ST_FLUSH : ST_START;
                     end else begin
                        state_q <= (lane_s == 3'd7) ? ST_START : ST_FLUSH;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               state_q <= ST_START;
            end
            ST_START: begin
               sha_start_q <= 1'b1;
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Ready is only trusted once the start pulse has been seen by the core.
               if (sha_ready && !sha_start_q) begin
                  shift_q   <= sha_digest;
                  idx_q     <= 5'd0;
                  d_valid_q <= 1'b1;
                  d_last_q  <= 1'b0;
                  state_q   <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (d_ready) begin
                  if (idx_q == LAST_IDX) begin
                     d_valid_q <= 1'b0;
                     d_last_q  <= 1'b0;
                     shift_q   <= 160'd0;
                     idx_q     <= 5'd0;
                     state_q   <= ST_CLEAR;
                  end else begin
                     shift_q  <= {shift_q[151:0], 8'd0};
                     idx_q    <= idx_q + 5'd1;
                     d_last_q <= (idx_q == (LAST_IDX - 5'd1));
                  end
               end
            end
            default: begin
               s_ready_q <= 1'b0;
               d_valid_q <= 1'b0;
               state_q   <= ST_CLEAR;
            end
         endcase
      end
   end

   assign s_ready   = s_ready_q;
   assign d_valid   = d_valid_q;
   assign d_data    = shift_q[159:152];
   assign d_last    = d_last_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign sha_start = sha_start_q;
   assign sha_reset = sha_reset_q;

endmodule

// File: tb/tb_sha1_byte_host.sv
// Bench for sha1_byte_host: a behavioural SHA1 core answers the load/start
// interface, and a software SHA1 model supplies expected digests via queues.
`timescale 1ns/1ps
module tb_sha1_byte_host;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [7:0]   s_data = 8'd0;
   logic         s_last = 1'b0;
   logic         s_empty = 1'b0;
   logic         d_valid;
   logic         d_ready = 1'b0;
   logic [7:0]   d_data;
   logic         d_last;
   logic         err;
   logic         busy;
   logic [63:0]  sha_in_data;
   logic [7:0]   sha_in_len;
   logic         sha_write;
   logic         sha_start;
   logic         sha_reset;
   logic [159:0] sha_digest = 160'd0;
   logic         sha_ready = 1'b0;

   int vec = 0;
   int miss = 0;

   always #5 clk = ~clk;

   sha1_byte_host #(.MAX_BYTES(7936)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_empty(s_empty),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_last(d_last),
      .err(err), .busy(busy),
      .sha_in_data(sha_in_data), .sha_in_len(sha_in_len), .sha_write(sha_write),
      .sha_start(sha_start), .sha_reset(sha_reset),
      .sha_digest(sha_digest), .sha_ready(sha_ready)
   );

   logic [7:0] stim_buf [0:8191];
   logic [7:0] core_buf [0:8191];
   logic [7:0] work_buf [0:8191];
   logic [7:0] exp_dig [$];
   int         exp_len [$];
   int         obs_len [$];
   int core_n = 0, core_cnt = 0;
   int n_reset = 0, n_start = 0, n_err = 0, n_dvalid = 0, n_collide = 0;

   function automatic logic [7:0] pad_byte(input int i, input int len, input int total);
      logic [63:0] bl;
      bl = 64'(len) * 64'd8;
      if (i < len) return work_buf[i];
      else if (i == len) return 8'h80;
      else if (i >= total - 8) return bl[8*(total-1-i) +: 8];
      else return 8'h00;
   endfunction

   function automatic logic [159:0] sha1_calc(input int len);
      logic [31:0] h [5];
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      int total;
      h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
      h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
      total = ((len + 9 + 63) / 64) * 64;
      for (int blk = 0; blk < total; blk += 64) begin
         for (int j = 0; j < 16; j++)
            w[j] = {pad_byte(blk+4*j, len, total), pad_byte(blk+4*j+1, len, total),
                    pad_byte(blk+4*j+2, len, total), pad_byte(blk+4*j+3, len, total)};
         for (int j = 16; j < 80; j++) begin
            t = w[j-3] ^ w[j-8] ^ w[j-14] ^ w[j-16];
            w[j] = {t[30:0], t[31]};
         end
         a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
         for (int j = 0; j < 80; j++) begin
            if (j < 20) begin f = (b & c) | (~b & d); k = 32'h5A827999; end
            else if (j < 40) begin f = b ^ c ^ d; k = 32'h6ED9EBA1; end
            else if (j < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else begin f = b ^ c ^ d; k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[j];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
         end
         h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
      end
      return {h[0], h[1], h[2], h[3], h[4]};
   endfunction

   // Behavioural SHA1 core plus event counters, evaluated away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sha_reset) begin core_n = 0; core_cnt = 0; sha_ready <= 1'b0; n_reset++; end
         if (sha_write) begin
            for (int k = 0; k < int'(sha_in_len) / 8; k++) begin
               if (core_n < 8192) begin core_buf[core_n] = sha_in_data[8*k +: 8]; core_n++; end
            end
            obs_len.push_back(int'(sha_in_len));
            if (sha_start) n_collide++;
         end
         if (sha_start) begin
            n_start++;
            for (int i = 0; i < core_n; i++) work_buf[i] = core_buf[i];
            sha_digest <= sha1_calc(core_n);
            sha_ready  <= 1'b0;
            core_cnt = 12;
         end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) sha_ready <= 1'b1;
         end
         if (err) n_err++;
         if (d_valid) n_dvalid++;
      end
   end

   task automatic model_push(input int n);
      logic [159:0] dg;
      for (int i = 0; i < n; i++) work_buf[i] = stim_buf[i];
      dg = sha1_calc(n);
      for (int b = 0; b < 20; b++) exp_dig.push_back(dg[159-8*b -: 8]);
      for (int w = 0; w < n / 8; w++) exp_len.push_back(64);
      if ((n % 8) != 0) exp_len.push_back((n % 8) * 8);
   endtask

   task automatic drive_bytes(input int n, input bit with_last);
      int items, i, guard;
      items = (n == 0) ? 1 : n;
      i = 0; guard = 0;
      while (i < items && guard < 20000) begin
         @(negedge clk); guard++;
         s_valid = 1'b1;
         s_data  = (n == 0) ? 8'h00 : stim_buf[i];
         s_last  = with_last && (i == items - 1);
         s_empty = (n == 0);
         if (s_ready) i++;
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
      vec++;
      if (i != items) begin miss++; $display("FAIL drive_timeout took %0d want %0d", i, items); end
   endtask

   task automatic recv_digest(input bit stall, output logic [159:0] got);
      int nb, guard;
      logic [7:0] held, exp;
      bit hold;
      nb = 0; guard = 0; hold = 1'b0; held = 8'd0; got = 160'd0;
      while (nb < 20 && guard < 3000) begin
         @(negedge clk); guard++;
         d_ready = stall ? (guard % 3 == 0) : 1'b1;
         if (hold) begin
            vec++;
            if (d_data !== held) begin miss++; $display("FAIL stall_hold d_data=%h want %h", d_data, held); end
         end
         hold = 1'b0;
         if (d_valid) begin
            if (d_ready) begin
               exp = (exp_dig.size() > 0) ? exp_dig.pop_front() : 8'hxx;
               vec++;
               if (d_data !== exp) begin miss++; $display("FAIL digest_byte%0d got %h want %h", nb, d_data, exp); end
               vec++;
               if (d_last !== (nb == 19)) begin miss++; $display("FAIL d_last byte%0d got %b want %b", nb, d_last, nb == 19); end
               got = {got[151:0], d_data};
               nb++;
            end else begin
               hold = 1'b1; held = d_data;
            end
         end
      end
      @(negedge clk);
      d_ready = 1'b0;
      vec++;
      if (nb != 20) begin miss++; $display("FAIL digest_timeout got %0d bytes want 20", nb); end
   endtask

   task automatic check_writes(input string name);
      int e, o;
      vec++;
      if (obs_len.size() != exp_len.size()) begin
         miss++; $display("FAIL %s write_count got %0d want %0d", name, obs_len.size(), exp_len.size());
      end
      while (exp_len.size() > 0 && obs_len.size() > 0) begin
         e = exp_len.pop_front(); o = obs_len.pop_front();
         vec++;
         if (o != e) begin miss++; $display("FAIL %s write_len got %0d want %0d", name, o, e); end
      end
      exp_len.delete(); obs_len.delete();
   endtask

   task automatic test_reset();
      int r0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      vec++;
      if ({s_ready, busy, d_valid, d_last, err, sha_write, sha_start, sha_reset} !== 8'b0100_0000) begin
         miss++; $display("FAIL reset_ctrl got %b want 01000000",
                          {s_ready, busy, d_valid, d_last, err, sha_write, sha_start, sha_reset});
      end
      vec++;
      if ({sha_in_data, sha_in_len, d_data} !== 80'd0) begin
         miss++; $display("FAIL reset_data got %h want 0", {sha_in_data, sha_in_len, d_data});
      end
      r0 = n_reset;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      vec++;
      if ({s_ready, busy} !== 2'b10) begin miss++; $display("FAIL idle_ready_busy got %b want 10", {s_ready, busy}); end
      vec++;
      if (n_reset - r0 != 1) begin miss++; $display("FAIL sha_reset_pulse got %0d want 1", n_reset - r0); end
   endtask

   task automatic test_abc(input bit stall);
      logic [159:0] got;
      int st0;
      stim_buf[0] = 8'h61; stim_buf[1] = 8'h62; stim_buf[2] = 8'h63;
      st0 = n_start;
      model_push(3);
      drive_bytes(3, 1'b1);
      recv_digest(stall, got);
      vec++;
      if (got !== 160'ha9993e364706816aba3e25717850c26c9cd0d89d) begin
         miss++; $display("FAIL abc_digest got %h want a9993e364706816aba3e25717850c26c9cd0d89d", got);
      end
      vec++;
      if (n_start - st0 != 1) begin miss++; $display("FAIL abc_starts got %0d want 1", n_start - st0); end
      check_writes("abc");
   endtask

   task automatic test_empty();
      logic [159:0] got;
      model_push(0);
      drive_bytes(0, 1'b1);
      recv_digest(1'b0, got);
      vec++;
      if (got !== 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709) begin
         miss++; $display("FAIL empty_digest got %h want da39a3ee5e6b4b0d3255bfef95601890afd80709", got);
      end
      check_writes("empty");
   endtask

   task automatic test_lengths();
      logic [159:0] got;
      int lens [5] = '{55, 56, 63, 64, 65};
      foreach (lens[j]) begin
         for (int i = 0; i < lens[j]; i++) stim_buf[i] = 8'($urandom);
         model_push(lens[j]);
         drive_bytes(lens[j], 1'b1);
         recv_digest(1'b0, got);
         check_writes($sformatf("len%0d", lens[j]));
      end
   endtask

   task automatic test_overflow();
      int e0, s0, v0;
      for (int i = 0; i < 7937; i++) stim_buf[i] = 8'($urandom);
      e0 = n_err; s0 = n_start; v0 = n_dvalid;
      drive_bytes(7937, 1'b1);
      repeat (40) @(negedge clk);
      vec++;
      if (n_err - e0 != 1) begin miss++; $display("FAIL ovf_err_cycles got %0d want 1", n_err - e0); end
      vec++;
      if (n_start - s0 != 0) begin miss++; $display("FAIL ovf_starts got %0d want 0", n_start - s0); end
      vec++;
      if (n_dvalid - v0 != 0) begin miss++; $display("FAIL ovf_dvalid got %0d want 0", n_dvalid - v0); end
      obs_len.delete();
      test_abc(1'b0);
   endtask

   task automatic test_reset_mid();
      int r0;
      for (int i = 0; i < 10; i++) stim_buf[i] = 8'($urandom);
      drive_bytes(10, 1'b0);
      reset_n = 1'b0;
      #1;
      vec++;
      if ({s_ready, busy, d_valid, sha_write, sha_start} !== 5'b01000) begin
         miss++; $display("FAIL mid_reset_outputs got %b want 01000", {s_ready, busy, d_valid, sha_write, sha_start});
      end
      repeat (2) @(negedge clk);
      r0 = n_reset;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      vec++;
      if (n_reset - r0 != 1) begin miss++; $display("FAIL mid_reset_pulse got %0d want 1", n_reset - r0); end
      obs_len.delete();
      test_abc(1'b0);
   endtask

   initial begin
      test_reset();
      test_abc(1'b0);
      test_empty();
      test_lengths();
      test_abc(1'b1);
      test_overflow();
      test_reset_mid();
      vec++;
      if (n_collide != 0) begin miss++; $display("FAIL start_with_write got %0d want 0", n_collide); end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
